// File: rtl/gpio_debounce_if.sv
// Debouncer pad/bus bundle: raw pads and holdoff in, debounced levels and edge events out.
// Purely combinational wiring; no flow control (levels sampled every clock).
interface gpio_debounce_if #(
    parameter int NIN = 16,
    parameter int CW  = 16
);
    logic [NIN-1:0] i_gpio;
    logic [CW-1:0]  i_holdoff;
    logic [NIN-1:0] o_gpio;
    logic [NIN-1:0] o_rise;
    logic [NIN-1:0] o_fall;
    logic           o_int;

    modport master (
        output i_gpio, i_holdoff,
        input  o_gpio, o_rise, o_fall, o_int
    );

    modport slave (
        input  i_gpio, i_holdoff,
        output o_gpio, o_rise, o_fall, o_int
    );
endinterface

// File: rtl/gpio_debounce.sv
// Per-line GPIO debouncer: 2-flop sync, then accept after i_holdoff+1 mismatching samples (2+i_holdoff+1 clk); no backpressure.
// Edge pulses o_rise/o_fall and o_int exist only when GPIO_DEBOUNCE_EDGE_EN is defined, otherwise tied to 0.
module gpio_debounce #(
    parameter int             NIN     = 16,
    parameter int             CW      = 16,
    parameter logic [NIN-1:0] DEFAULT = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    gpio_debounce_if.slave   bus
);

    (* ASYNC_REG = "TRUE" *) logic [NIN-1:0] meta_q;
    (* ASYNC_REG = "TRUE" *) logic [NIN-1:0] sync_q;
    logic [NIN-1:0]          gpio_q, gpio_d;
    logic [NIN-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NIN-1:0]          acc;

    // A counter only ever advances while below holdoff, so the >= compare bounds it without wrap.
    always_comb begin
        cnt_d = '0;
        acc   = '0;
        for (int k = 0; k < NIN; k++) begin
            if (sync_q[k] != gpio_q[k]) begin
                if (cnt_q[k] >= bus.i_holdoff) begin
                    acc[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        gpio_d = gpio_q ^ acc;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= DEFAULT;
            sync_q <= DEFAULT;
            gpio_q <= DEFAULT;
            cnt_q  <= '0;
        end else begin
            meta_q <= bus.i_gpio;
            sync_q <= meta_q;
            gpio_q <= gpio_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.o_gpio = gpio_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
    logic [NIN-1:0] rise_q, rise_d;
    logic [NIN-1:0] fall_q, fall_d;
    logic           int_q, int_d;

    always_comb begin
        rise_d = acc & sync_q;
        fall_d = acc & ~sync_q;
        int_d  = |(rise_q | fall_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rise_q <= '0;
            fall_q <= '0;
            int_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            int_q  <= int_d;
        end
    end

    assign bus.o_rise = rise_q;
    assign bus.o_fall = fall_q;
    assign bus.o_int  = int_q;
`else
    assign bus.o_rise = '0;
    assign bus.o_fall = '0;
    assign bus.o_int  = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce (NIN=16, CW=16, DEFAULT=16'h0004); edge checks adapt to GPIO_DEBOUNCE_EDGE_EN.
module tb_gpio_debounce;

`ifdef GPIO_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    localparam logic [15:0] DEF = 16'h0004;

    logic i_clk = 1'b0;
    logic i_reset;
    int   checks   = 0;
    int   failures = 0;

    gpio_debounce_if #(.NIN(16), .CW(16)) bus ();

    gpio_debounce #(.NIN(16), .CW(16), .DEFAULT(DEF)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ev(input logic [15:0] v);
        return EDGE_EN ? v : 16'h0000;
    endfunction

    function automatic logic ev1(input logic v);
        return EDGE_EN ? v : 1'b0;
    endfunction

    logic seen;

    initial begin
        i_reset       = 1'b1;
        bus.i_gpio    = 16'h0000;
        bus.i_holdoff = 16'd3;
        tick(3);
        check("rst_gpio", 32'(bus.o_gpio), 32'(DEF));
        check("rst_rise", 32'(bus.o_rise), 32'h0);
        check("rst_fall", 32'(bus.o_fall), 32'h0);
        check("rst_int",  32'(bus.o_int),  32'h0);

        // Idle matching DEFAULT after release: nothing moves.
        bus.i_gpio = DEF;
        i_reset    = 1'b0;
        tick(4);
        check("idle_gpio", 32'(bus.o_gpio), 32'(DEF));
        check("idle_rise", 32'(bus.o_rise), 32'h0);

        // Holdoff 3: line 0 rises, accepted exactly 6 clocks later.
        bus.i_gpio = 16'h0005;
        tick(5);
        check("h3_before", 32'(bus.o_gpio), 32'h0004);
        check("h3_int_pre", 32'(bus.o_int), 32'h0);
        tick();
        check("h3_gpio", 32'(bus.o_gpio), 32'h0005);
        check("h3_rise", 32'(bus.o_rise), 32'(ev(16'h0001)));
        check("h3_int0", 32'(bus.o_int),  32'h0);
        tick();
        check("h3_rise_clr", 32'(bus.o_rise), 32'h0);
        check("h3_int1", 32'(bus.o_int), 32'(ev1(1'b1)));
        tick();
        check("h3_int_clr", 32'(bus.o_int), 32'h0);

        // Glitch on line 1 lasting 3 clocks never reaches o_gpio.
        bus.i_gpio = 16'h0007;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | (|bus.o_rise) | bus.o_int | (bus.o_gpio != 16'h0005);
        end
        bus.i_gpio = 16'h0005;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | (|bus.o_rise) | bus.o_int | (bus.o_gpio != 16'h0005);
        end
        check("glitch_seen", 32'(seen), 32'h0);
        check("glitch_gpio", 32'(bus.o_gpio), 32'h0005);

        // Holdoff 0: lines 0 and 2 fall, then all lines rise, 3 clocks each.
        bus.i_holdoff = 16'd0;
        bus.i_gpio    = 16'h0000;
        tick(2);
        check("h0_fall_pre", 32'(bus.o_gpio), 32'h0005);
        tick();
        check("h0_fall_gpio", 32'(bus.o_gpio), 32'h0000);
        check("h0_fall", 32'(bus.o_fall), 32'(ev(16'h0005)));
        tick(2);
        bus.i_gpio = 16'hFFFF;
        tick(2);
        check("h0_rise_pre", 32'(bus.o_gpio), 32'h0000);
        tick();
        check("h0_all_gpio", 32'(bus.o_gpio), 32'hFFFF);
        check("h0_all_rise", 32'(bus.o_rise), 32'(ev(16'hFFFF)));
        check("h0_all_int0", 32'(bus.o_int),  32'h0);
        tick();
        check("h0_rise_clr", 32'(bus.o_rise), 32'h0);
        check("h0_int1", 32'(bus.o_int), 32'(ev1(1'b1)));
        tick();
        check("h0_int_once", 32'(bus.o_int), 32'h0);

        // Holdoff 100 lowered to 10 while count sits at 50: accept next sample.
        bus.i_holdoff = 16'd100;
        bus.i_gpio    = 16'hFFFE;
        tick(52);
        check("lower_pre", 32'(bus.o_gpio), 32'hFFFF);
        bus.i_holdoff = 16'd10;
        tick();
        check("lower_gpio", 32'(bus.o_gpio), 32'hFFFE);
        check("lower_fall", 32'(bus.o_fall), 32'(ev(16'h0001)));
        tick(2);

        // Reset with line 0 count at 2 of 3.
        bus.i_holdoff = 16'd3;
        bus.i_gpio    = 16'hFFFF;
        tick(4);
        i_reset = 1'b1;
        tick();
        check("mrst_gpio", 32'(bus.o_gpio), 32'(DEF));
        check("mrst_rise", 32'(bus.o_rise), 32'h0);
        check("mrst_fall", 32'(bus.o_fall), 32'h0);
        tick();
        i_reset = 1'b0;
        tick();
        check("rel_gpio", 32'(bus.o_gpio), 32'(DEF));
        check("rel_pulse", 32'(bus.o_rise | bus.o_fall), 32'h0);
        check("rel_int", 32'(bus.o_int), 32'h0);
        tick(4);
        check("rel_hold", 32'(bus.o_gpio), 32'(DEF));
        tick();
        check("rel_gpio_acc", 32'(bus.o_gpio), 32'hFFFF);
        check("rel_rise", 32'(bus.o_rise), 32'(ev(16'hFFFB)));
        tick();
        check("rel_int1", 32'(bus.o_int), 32'(ev1(1'b1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 SHALL have parameter NIN, default 16, number of GPIO input lines (1..16).
REQ-002 SHALL have parameter CW, default 16, width of each per-line stability counter.
REQ-003 SHALL have parameter DEFAULT, NIN bits, default 0, reset value of synchronizers and debounced outputs.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_gpio  input  NIN  raw, asynchronous pad inputs.
REQ-007 SHALL have port i_holdoff  input  CW  stability requirement, in clocks beyond one.
REQ-008 SHALL have port o_gpio  output  NIN  debounced levels, feeding the GPIO controller's input bus.
REQ-009 SHALL have port o_rise  output  NIN  one-clock pulse per line on accepted 0->1 transition.
REQ-010 SHALL have port o_fall  output  NIN  one-clock pulse per line on accepted 1->0 transition.
REQ-011 SHALL have port o_int  output  1  registered OR of the previous cycle's o_rise|o_fall.

Function
REQ-012 SHALL pass i_gpio through a two-flop synchronizer (x, then q), both marked ASYNC_REG; only q feeds the debounce logic.
REQ-013 SHALL keep one CW-bit counter per line; when q[k]==o_gpio[k], counter[k] SHALL load 0 on the next clock.
REQ-014 SHALL, when q[k]!=o_gpio[k] and counter[k] < i_holdoff, increment counter[k] by one.
REQ-015 SHALL, when q[k]!=o_gpio[k] and counter[k] >= i_holdoff, set o_gpio[k] to q[k] and clear counter[k] at that clock edge.
REQ-016 SHALL therefore accept a new level after i_holdoff+1 consecutive mismatching q samples; pin-to-o_gpio latency = 2 + i_holdoff + 1 clocks.
REQ-017 SHALL accept after exactly one mismatching sample when i_holdoff==0.
REQ-018 SHALL never wrap a counter; the >= compare bounds it at i_holdoff, including the 2^CW-1 maximum.
REQ-019 SHALL use the current i_holdoff each cycle; a holdoff lowered below an in-progress count causes acceptance on the next mismatching sample.
REQ-020 SHALL restart counter[k] from 0 on any single matching sample (glitch shorter than i_holdoff+1 clocks never reaches o_gpio).
REQ-021 SHALL register o_rise[k]/o_fall[k] in the same edge that updates o_gpio[k]; each is high for exactly one clock.
REQ-022 SHALL assert o_int one clock after any o_rise/o_fall bit, for one clock per event cycle; simultaneous events on several lines produce one o_int cycle.
REQ-023 SHALL treat lines fully independently; simultaneous transitions on different lines are each debounced by their own counter.

Reset
REQ-024 SHALL on i_reset set x, q and o_gpio to DEFAULT, all counters to 0, o_rise, o_fall and o_int to 0.
REQ-025 SHALL abandon any in-progress count on reset mid-operation; no edge pulse is produced on the cycle reset is released.
REQ-026 SHALL, after reset, accept an i_gpio level differing from DEFAULT only via the normal holdoff path (one edge pulse).

Configuration
REQ-027 SHALL compile edge reporting only when macro GPIO_DEBOUNCE_EDGE_EN is defined: o_rise, o_fall, o_int as above.
REQ-028 SHALL, without GPIO_DEBOUNCE_EDGE_EN, tie o_rise, o_fall and o_int to 0 and omit their registers; o_gpio behaviour is unchanged.

Verification
REQ-029 SHALL cover: NIN=16, CW=16, i_holdoff=3, i_gpio[0] 0->1 held -> o_gpio[0]=1 exactly 6 clocks later, o_rise[0] 1 clock wide same cycle, o_int one clock after.
REQ-030 SHALL cover: i_holdoff=3, i_gpio[1] high for 3 clocks then low -> o_gpio[1] stays 0, no o_rise/o_int.
REQ-031 SHALL cover: i_holdoff=0, i_gpio=16'hFFFF from 0 -> o_gpio=16'hFFFF 3 clocks later, o_rise=16'hFFFF for one clock, single o_int pulse.
REQ-032 SHALL cover: i_holdoff=100, count at 50, i_holdoff changed to 10 -> acceptance on next mismatching sample.
REQ-033 SHALL cover: i_reset asserted with count at 2 of 3, DEFAULT=16'h0004 -> o_gpio=16'h0004, no pulses, counts restart from 0 after release.
REQ-034 SHALL cover: build without GPIO_DEBOUNCE_EDGE_EN, repeat REQ-029 -> identical o_gpio timing, o_rise/o_fall/o_int constant 0.
